class_search: RTL and testbench
===============================

# class_search

Associative-search (inference) stage of the sparse HDC datapath: the read-side counterpart of the class-hypervector generator. It accepts one binary query hypervector, reads every stored class hypervector from the class memory in index order, and scores each one by overlap: popcount(query AND class). It then returns the index and score of the best-matching class. It sits between the query encoder and the result/output logic, and only reads class memory.

## Interface
- DIM, 10: hypervector width in bits
- NUM_CLASSES, 26: number of stored classes (index 0 = a … 25 = z)
- IDX_W, 5: class index width, ≥ clog2(NUM_CLASSES)
- SCORE_W, 4: score width, = clog2(DIM+1)

- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- q_valid  in  1  query present
- q_hv  in  DIM  query hypervector
- q_ready  out  1  block can accept a query
- cls_rd_en  out  1  class memory read strobe
- cls_addr  out  IDX_W  class index being read
- cls_rdata  in  DIM  class hypervector; valid exactly 1 cycle after a cycle with cls_rd_en=1
- res_valid  out  1  result available
- res_class  out  IDX_W  best class index
- res_score  out  SCORE_W  best overlap score
- res_ready  in  1  consumer accepts result

## Operation
- FSM states: IDLE, SCAN, DRAIN, DONE.
- IDLE:
  - q_ready=1.
  - On q_valid&q_ready: latch q_hv into the query register, clear best_score=0 and best_class=0, set rd_ptr=0, go to SCAN.
- SCAN:
  - Drive cls_rd_en=1 and cls_addr=rd_ptr; increment rd_ptr every cycle.
  - After issuing addr NUM_CLASSES-1, go to DRAIN.
- Compare stage (pipelined, runs in SCAN and DRAIN):
  - A registered delay of cls_rd_en/cls_addr marks when cls_rdata is valid.
  - score = popcount(query & cls_rdata), zero-extended to SCORE_W.
  - If score > best_score (strict), update best_score and best_class. Ties keep the earlier, lower index.
- DRAIN: one cycle; the compare for the last class completes, then go to DONE.
- DONE:
  - res_valid=1; res_class and res_score hold the best values.
  - On res_valid&res_ready: go to IDLE.
  - Result is held stable until accepted.
- q_ready=0 in SCAN, DRAIN and DONE. A query offered then is not consumed.
- Query values are read only at the accept edge; later changes to q_hv have no effect.
- An all-zero query or an all-zero memory gives res_class=0, res_score=0.
- rst high (at any time, including mid-SCAN) → on that edge:
  - state IDLE; cls_rd_en=0; cls_addr=0; res_valid=0; res_class=0; res_score=0; pointers and pipeline valid cleared.
  - Any in-flight search is discarded.
- q_ready=0 while rst is high.

## Timing
- Accept at edge E0. cls_addr=k with cls_rd_en=1 during the cycle following edge E0+k, for k=0…NUM_CLASSES-1.
- cls_rd_en is high for exactly NUM_CLASSES consecutive cycles per query, with no gaps.
- The compare for class k commits at edge E0+k+2.
- res_valid rises after edge E0+NUM_CLASSES+1 (27 cycles with defaults).
- Accept edge Ea (res_valid&res_ready) → q_ready=1 in the next cycle. A new query can be accepted at edge Ea+1, so back-to-back throughput is NUM_CLASSES+3 cycles per query.
- All outputs are registered except q_ready, which is decoded from state and rst.

## Test plan
- Reset: hold rst 2 cycles mid-SCAN (at cls_addr=7) → next cycle cls_rd_en=0, res_valid=0, q_ready=1, and no result ever appears for that query.
- Unique best match: memory class k = 10'b0 except class 3 = 10'b1111001111; query 10'b1111001111 → res_class=3, res_score=8, res_valid after exactly 27 cycles, cls_addr sweeps 0..25.
- Tie: class 2 = 10'b0000111000 and class 9 = 10'b0000111000, all others 0; query 10'b0000111000 → res_class=2, res_score=3.
- Zero/full: query 10'b0000000000 with arbitrary memory → res_class=0, res_score=0. Query 10'b1111111111 with class 25 = 10'b1111111111 and others ≤5 ones → res_class=25, res_score=10.
- Handshake: hold res_ready=0 for 5 cycles while q_valid=1 with a new query → result stable, q_ready=0, second query not taken. Raise res_ready → second query accepted one cycle later, and the second search scans all 26 classes.
- Query isolation: change q_hv every cycle during SCAN → result matches the value latched at the accept edge.

Source files
------------

// File: rtl/class_search.sv
// class_search: associative search over stored class hypervectors.
// Scores each class by popcount(query & class) and reports the best.
module class_search #(
   parameter int DIM         = 10,
   parameter int NUM_CLASSES = 26,
   parameter int IDX_W       = 5,
   parameter int SCORE_W     = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               q_valid,
   input  logic [DIM-1:0]     q_hv,
   output logic               q_ready,
   output logic               cls_rd_en,
   output logic [IDX_W-1:0]   cls_addr,
   input  logic [DIM-1:0]     cls_rdata,
   output logic               res_valid,
   output logic [IDX_W-1:0]   res_class,
   output logic [SCORE_W-1:0] res_score,
   input  logic               res_ready
);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CLASSES - 1);

   state_t             r_state;
   state_t             w_next;
   logic               w_accept;
   logic [DIM-1:0]     r_query;
   logic               r_rd_en;
   logic [IDX_W-1:0]   r_addr;
   logic               r_cmp_vld;
   logic [IDX_W-1:0]   r_cmp_addr;
   logic [SCORE_W-1:0] r_best_score;
   logic [IDX_W-1:0]   r_best_class;
   logic               r_res_valid;
   logic [DIM-1:0]     w_and;
   logic [SCORE_W-1:0] w_score;

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (q_valid) begin
               w_accept = 1'b1;
               w_next   = SCAN;
            end
         end
         SCAN:    if (r_addr == LAST) w_next = DRAIN;
         DRAIN:   w_next = DONE;
         DONE:    if (res_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   assign w_and = r_query & cls_rdata;

   always_comb begin
      w_score = '0;
      for (int i = 0; i < DIM; i++)
         w_score = w_score + SCORE_W'(w_and[i]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_query      <= '0;
         r_rd_en      <= 1'b0;
         r_addr       <= '0;
         r_cmp_vld    <= 1'b0;
         r_cmp_addr   <= '0;
         r_best_score <= '0;
         r_best_class <= '0;
         r_res_valid  <= 1'b0;
      end else begin
         r_rd_en     <= (w_next == SCAN);
         r_cmp_vld   <= r_rd_en;
         r_cmp_addr  <= r_addr;
         r_res_valid <= (w_next == DONE);
         if (w_accept) begin
            r_query      <= q_hv;
            r_best_score <= '0;
            r_best_class <= '0;
            r_addr       <= '0;
         end else begin
            if (r_state == SCAN)
               r_addr <= (w_next == SCAN) ? r_addr + 1'b1 : '0;
            // strict compare keeps the lower index on ties
            if (r_cmp_vld && (w_score > r_best_score)) begin
               r_best_score <= w_score;
               r_best_class <= r_cmp_addr;
            end
         end
      end
   end

   assign q_ready   = (r_state == IDLE) && !rst;
   assign cls_rd_en = r_rd_en;
   assign cls_addr  = r_addr;
   assign res_valid = r_res_valid;
   assign res_class = r_best_class;
   assign res_score = r_best_score;

endmodule

// File: tb/tb_class_search.sv
// Directed bench for class_search with a one-cycle-latency class memory.
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_class_search;

   logic       clk = 1'b0;
   logic       rst;
   logic       q_valid;
   logic [9:0] q_hv;
   logic       q_ready;
   logic       cls_rd_en;
   logic [4:0] cls_addr;
   logic [9:0] cls_rdata;
   logic       res_valid;
   logic [4:0] res_class;
   logic [3:0] res_score;
   logic       res_ready;

   logic [9:0] mem [26];

   int n_chk  = 0;
   int n_fail = 0;

   class_search dut (
      .clk       (clk),
      .rst       (rst),
      .q_valid   (q_valid),
      .q_hv      (q_hv),
      .q_ready   (q_ready),
      .cls_rd_en (cls_rd_en),
      .cls_addr  (cls_addr),
      .cls_rdata (cls_rdata),
      .res_valid (res_valid),
      .res_class (res_class),
      .res_score (res_score),
      .res_ready (res_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (cls_rd_en) cls_rdata <= mem[cls_addr];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_query(input logic [9:0] q);
      chk("q_ready_before_accept", 32'(q_ready), 1);
      q_valid = 1'b1;
      q_hv    = q;
      tick();
      q_valid = 1'b0;
   endtask

   // Called 1ns after the accept edge; follows the scan to the result.
   task automatic wait_result(input bit scramble, input string tag,
                              input int exp_cls, input int exp_score);
      int lat;
      int nrd;
      bit ok;
      lat = -1;
      nrd = 0;
      ok  = 1'b1;
      for (int c = 0; c < 60; c++) begin
         if (res_valid) begin
            lat = c;
            break;
         end
         if (cls_rd_en) begin
            if (cls_addr !== 5'(nrd)) ok = 1'b0;
            nrd++;
         end
         if (scramble) q_hv = 10'($urandom);
         tick();
      end
      chk({tag, "_latency"}, 32'(lat), 27);
      chk({tag, "_reads"}, 32'(nrd), 26);
      chk({tag, "_addr_seq"}, 32'(ok), 1);
      chk({tag, "_class"}, 32'(res_class), 32'(exp_cls));
      chk({tag, "_score"}, 32'(res_score), 32'(exp_score));
   endtask

   task automatic release_result(input string tag);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk({tag, "_rel_q_ready"}, 32'(q_ready), 1);
      chk({tag, "_rel_res_valid"}, 32'(res_valid), 0);
   endtask

   initial begin
      bit seen;
      rst       = 1'b1;
      q_valid   = 1'b0;
      q_hv      = '0;
      res_ready = 1'b0;
      for (int i = 0; i < 26; i++) mem[i] = '0;
      mem[3] = 10'b1111001111;

      tick();
      tick();
      chk("rst_q_ready", 32'(q_ready), 0);
      chk("rst_rd_en", 32'(cls_rd_en), 0);
      chk("rst_addr", 32'(cls_addr), 0);
      chk("rst_res_valid", 32'(res_valid), 0);
      chk("rst_res_class", 32'(res_class), 0);
      chk("rst_res_score", 32'(res_score), 0);
      rst = 1'b0;
      #1;
      chk("post_rst_q_ready", 32'(q_ready), 1);

      // Reset mid-scan at cls_addr 7.
      start_query(10'b1111001111);
      for (int c = 0; c < 40; c++) begin
         if (cls_rd_en && cls_addr == 5'd7) break;
         tick();
      end
      chk("midscan_addr7", 32'(cls_addr), 7);
      rst = 1'b1;
      tick();
      chk("midscan_rd_en", 32'(cls_rd_en), 0);
      chk("midscan_res_valid", 32'(res_valid), 0);
      chk("midscan_q_ready_in_rst", 32'(q_ready), 0);
      tick();
      rst = 1'b0;
      #1;
      chk("midscan_q_ready", 32'(q_ready), 1);
      seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (res_valid || cls_rd_en) seen = 1'b1;
         tick();
      end
      chk("midscan_no_result", 32'(seen), 0);

      // Unique best match.
      start_query(10'b1111001111);
      wait_result(1'b0, "unique", 3, 8);

      // Held result while a second query waits.
      mem[2] = 10'b0000111000;
      mem[9] = 10'b0000111000;
      q_valid = 1'b1;
      q_hv    = 10'b0000111000;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("hold_res_valid", 32'(res_valid), 1);
         chk("hold_res_class", 32'(res_class), 3);
         chk("hold_res_score", 32'(res_score), 8);
         chk("hold_q_ready", 32'(q_ready), 0);
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk("hs_q_ready", 32'(q_ready), 1);
      chk("hs_res_valid", 32'(res_valid), 0);
      tick();
      q_valid = 1'b0;
      chk("hs_accepted", 32'(cls_rd_en), 1);
      wait_result(1'b0, "tie", 2, 3);
      release_result("tie");

      // All-zero query.
      start_query(10'b0000000000);
      wait_result(1'b0, "zero", 0, 0);
      release_result("zero");

      // Full query, class 25 all ones, others at most 5 ones.
      for (int i = 0; i < 25; i++) mem[i] = 10'b0000011111;
      mem[0]  = 10'b1010101010;
      mem[25] = 10'b1111111111;
      start_query(10'b1111111111);
      wait_result(1'b0, "full", 25, 10);
      release_result("full");

      // Query changes during scan must not matter.
      for (int i = 0; i < 26; i++) mem[i] = '0;
      mem[4] = 10'b0000011111;
      mem[7] = 10'b1111111110;
      mem[20] = 10'b1111100000;
      start_query(10'b0000011111);
      wait_result(1'b1, "isolate", 4, 5);
      release_result("isolate");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
